operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Decode-to-execute pipeline stage wrapped around the 32-entry register file.
- Drives the register-file read addresses and captures the operands.
- Bypasses same-cycle writeback data, detects load-use hazards, and holds one instruction behind a valid/ready handshake toward the execute stage.
- Sits between instruction decode (upstream) and the ALU/execute stage (downstream).

Parameters:
DATA_WIDTH, 32, operand/data width
ADDR_WIDTH, 5, register address width (32 registers, register 0 hardwired to zero)

Ports:
clock  input  1  stage clock, rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous kill of held entry and hazard shadow
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage accepts the instruction this cycle
in_rs  input  ADDR_WIDTH  source register A address
in_rt  input  ADDR_WIDTH  source register B address
in_rd  input  ADDR_WIDTH  destination register address
in_imm  input  DATA_WIDTH  sign-extended immediate
in_reg_write  input  1  instruction writes rd
in_mem_read  input  1  instruction is a load
rf_read_address_1  output  ADDR_WIDTH  to register file port 1
rf_read_address_2  output  ADDR_WIDTH  to register file port 2
rf_data_1  input  DATA_WIDTH  register file port 1 data
rf_data_2  input  DATA_WIDTH  register file port 2 data
wb_write_enable  input  1  writeback writes the register file this cycle
wb_write_address  input  ADDR_WIDTH  writeback destination
wb_write_data  input  DATA_WIDTH  writeback data
out_valid  output  1  held entry valid
out_ready  input  1  execute accepts the held entry
out_operand_a  output  DATA_WIDTH  captured operand A
out_operand_b  output  DATA_WIDTH  captured operand B
out_imm  output  DATA_WIDTH  captured immediate
out_rd  output  ADDR_WIDTH  captured destination
out_reg_write  output  1  captured write flag
out_mem_read  output  1  captured load flag

Behaviour:
- Reset (reset low, asynchronous): all out_* registers 0, shadow_valid 0, shadow_rd 0. in_ready is combinational and follows from these values.
- rf_read_address_1 = in_rs and rf_read_address_2 = in_rt, combinationally, every cycle.
- Bypass for operand A:
  - in_rs == 0 → 0.
  - else if wb_write_enable && wb_write_address == in_rs → wb_write_data.
  - else → rf_data_1.
  - Operand B uses the same rule with in_rt and rf_data_2.
- Load-use hazard `hz` = in_valid && ((held_hit) || (shadow_hit)):
  - held_hit: out_valid && out_mem_read && out_rd != 0 && (out_rd == in_rs || out_rd == in_rt).
  - shadow_hit: shadow_valid && shadow_rd != 0 && (shadow_rd == in_rs || shadow_rd == in_rt).
- in_ready = (!out_valid || out_ready) && !hz && !flush.
- Capture: when in_valid && in_ready, all out_* registers load from the in_*/bypassed values and out_valid becomes 1 on the next edge. Latency is 1 cycle.
- Drain: when out_valid && out_ready && no capture, out_valid becomes 0. Payload registers hold their values; the value of a payload field is don't-care while out_valid is 0.
- Hold: out_valid && !out_ready keeps every out_* register stable. Upstream sees in_ready 0.
- Shadow:
  - On each edge, shadow_valid <= (out_valid && out_ready && out_mem_read && out_reg_write).
  - shadow_rd <= out_rd.
  - The shadow covers the load for the one cycle after it leaves, so a dependent instruction gets exactly 2 bubble cycles after the load is accepted downstream.
- Flush (synchronous, highest priority after reset): out_valid <= 0, shadow_valid <= 0, no capture that cycle.
- Simultaneous drain and capture in one cycle is a pass-through: out_valid stays 1 with the new payload.
- Register 0 is never bypassed and never triggers a hazard.

Test Plan:
- Reset low mid-transfer with out_valid=1 → out_valid, out_operand_a, out_rd all 0 immediately, without waiting for a clock edge. After release, the first in_valid is captured one cycle later.
- rs=3, rf_data_1=0x11, wb_write_enable=1, wb_write_address=3, wb_write_data=0xDEADBEEF, in_valid=1, out_ready=1 → next cycle out_operand_a=0xDEADBEEF. The same stimulus with rs=0 → out_operand_a=0.
- Load (rd=5, mem_read=1, reg_write=1) followed by an instruction with rs=5, out_ready=1 every cycle → in_ready low for 2 cycles. The dependent instruction reaches out_valid 3 cycles after the load.
- Hold out_ready=0 for 4 cycles with out_valid=1 and a second in_valid pending → in_ready=0 and outputs unchanged. When out_ready=1, the second instruction is captured in that same cycle (pass-through).
- Assert flush with out_valid=1 and in_valid=1 → next cycle out_valid=0, nothing captured, shadow cleared. The next in_valid is accepted with no hazard stall.
- Back-to-back independent instructions with out_ready=1 constantly → one capture per cycle, out_valid continuously 1, no bubbles.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads the register file, bypasses same-cycle writeback,
// stalls on load-use hazards and holds one instruction for the execute stage.
module operand_fetch_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs,
  input  logic [ADDR_WIDTH-1:0] in_rt,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  output logic [ADDR_WIDTH-1:0] rf_read_address_1,
  output logic [ADDR_WIDTH-1:0] rf_read_address_2,
  input  logic [DATA_WIDTH-1:0] rf_data_1,
  input  logic [DATA_WIDTH-1:0] rf_data_2,
  input  logic                  wb_write_enable,
  input  logic [ADDR_WIDTH-1:0] wb_write_address,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_operand_a,
  output logic [DATA_WIDTH-1:0] out_operand_b,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read
);

  // Handshake: a transfer happens on any rising edge where valid && ready are
  // both high; valid never waits on ready, and a held payload is stable until
  // it transfers (or a flush/reset discards it).

  logic                  shadow_valid;
  logic [ADDR_WIDTH-1:0] shadow_rd;
  logic                  held_hit;
  logic                  shadow_hit;
  logic                  hz;
  logic                  capture;
  logic [DATA_WIDTH-1:0] byp_a;
  logic [DATA_WIDTH-1:0] byp_b;

  assign rf_read_address_1 = in_rs;
  assign rf_read_address_2 = in_rt;

  always_comb begin
    byp_a = rf_data_1;
    byp_b = rf_data_2;
    if (in_rs == '0)
      byp_a = '0;
    else if (wb_write_enable && (wb_write_address == in_rs))
      byp_a = wb_write_data;
    if (in_rt == '0)
      byp_b = '0;
    else if (wb_write_enable && (wb_write_address == in_rt))
      byp_b = wb_write_data;
  end

  // The shadow keeps a load visible for the one cycle after it leaves,
  // covering the gap before its data reaches the writeback bypass.
  always_comb begin
    held_hit   = out_valid && out_mem_read && (out_rd != '0) &&
                 ((out_rd == in_rs) || (out_rd == in_rt));
    shadow_hit = shadow_valid && (shadow_rd != '0) &&
                 ((shadow_rd == in_rs) || (shadow_rd == in_rt));
    hz         = in_valid && (held_hit || shadow_hit);
    in_ready   = (!out_valid || out_ready) && !hz && !flush;
    capture    = in_valid && in_ready;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      out_operand_a <= '0;
      out_operand_b <= '0;
      out_imm       <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      shadow_valid  <= 1'b0;
      shadow_rd     <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      shadow_valid <= 1'b0;
      shadow_rd    <= out_rd;
    end else begin
      shadow_valid <= out_valid && out_ready && out_mem_read && out_reg_write;
      shadow_rd    <= out_rd;
      if (capture) begin
        out_valid     <= 1'b1;
        out_operand_a <= byp_a;
        out_operand_b <= byp_b;
        out_imm       <= in_imm;
        out_rd        <= in_rd;
        out_reg_write <= in_reg_write;
        out_mem_read  <= in_mem_read;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus random traffic, all
// checked against a transaction-level model with an expected-payload queue.
module tb_operand_fetch_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int PW = 3 * DW + AW + 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_rs = '0, in_rt = '0, in_rd = '0;
  logic [DW-1:0] in_imm = '0;
  logic          in_reg_write = 1'b0, in_mem_read = 1'b0;
  logic [AW-1:0] rf_read_address_1, rf_read_address_2;
  logic [DW-1:0] rf_data_1 = '0, rf_data_2 = '0;
  logic          wb_write_enable = 1'b0;
  logic [AW-1:0] wb_write_address = '0;
  logic [DW-1:0] wb_write_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_operand_a, out_operand_b, out_imm;
  logic [AW-1:0] out_rd;
  logic          out_reg_write, out_mem_read;

  operand_fetch_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .rf_read_address_1(rf_read_address_1), .rf_read_address_2(rf_read_address_2),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .wb_write_enable(wb_write_enable), .wb_write_address(wb_write_address),
    .wb_write_data(wb_write_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_operand_a(out_operand_a), .out_operand_b(out_operand_b),
    .out_imm(out_imm), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: instructions accepted and not yet consumed, packed as
  // {operand_a, operand_b, imm, rd, reg_write, mem_read}.
  logic [PW-1:0] exp_q[$];
  // A load that left downstream on the previous edge still blocks its rd.
  logic          load_left_last;
  logic [AW-1:0] load_left_rd;
  logic          obs_ready, obs_valid;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] operand(input logic [AW-1:0] r, input logic [DW-1:0] rf);
    if (r == 0) return '0;
    if (wb_write_enable && wb_write_address == r) return wb_write_data;
    return rf;
  endfunction

  function automatic logic depends_on(input logic [AW-1:0] r);
    return (r != 0) && (r == in_rs || r == in_rt);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    load_left_last = 1'b0;
    load_left_rd   = '0;
  endtask

  // Called right after inputs change following a falling edge; checks this
  // cycle, advances the model across the next rising edge, returns at the
  // following falling edge.
  task automatic cycle();
    logic [PW-1:0] front;
    logic          held, stall, exp_ready, leaving, accept;
    #1;
    held  = (exp_q.size() != 0);
    front = held ? exp_q[0] : '0;
    stall = in_valid && ((held && front[0] && depends_on(front[AW+1:2])) ||
                         (load_left_last && depends_on(load_left_rd)));
    exp_ready = (!held || out_ready) && !stall && !flush;
    obs_ready = in_ready;
    obs_valid = out_valid;
    check("in_ready", in_ready, exp_ready);
    check("rf_addr_1", rf_read_address_1, in_rs);
    check("rf_addr_2", rf_read_address_2, in_rt);
    check("out_valid", out_valid, held);
    if (held)
      check("payload", {out_operand_a, out_operand_b, out_imm, out_rd, out_reg_write, out_mem_read}, front);
    accept  = in_valid && exp_ready;
    leaving = held && (out_ready || flush);
    load_left_last = !flush && held && out_ready && front[0] && front[1];
    load_left_rd   = front[AW+1:2];
    if (leaving) void'(exp_q.pop_front());
    if (accept)
      exp_q.push_back({operand(in_rs, rf_data_1), operand(in_rt, rf_data_2),
                       in_imm, in_rd, in_reg_write, in_mem_read});
    @(negedge clock);
  endtask

  // driver tasks
  task automatic idle_inputs();
    in_valid = 0; flush = 0; out_ready = 1; wb_write_enable = 0;
    in_rs = 0; in_rt = 0; in_rd = 0; in_mem_read = 0; in_reg_write = 0;
  endtask

  task automatic drive_instr(input logic [AW-1:0] rs, rt, rd, input logic rw, mr);
    in_valid = 1; in_rs = rs; in_rt = rt; in_rd = rd;
    in_reg_write = rw; in_mem_read = mr;
    in_imm = $urandom(); rf_data_1 = $urandom(); rf_data_2 = $urandom();
  endtask

  task automatic drive_random();
    in_valid = ($urandom_range(0, 9) < 7);
    in_rs = AW'($urandom_range(0, 7)); in_rt = AW'($urandom_range(0, 7));
    in_rd = AW'($urandom_range(0, 7));
    in_imm = $urandom(); in_reg_write = $urandom_range(0, 1);
    in_mem_read = ($urandom_range(0, 9) < 3);
    rf_data_1 = $urandom(); rf_data_2 = $urandom();
    wb_write_enable = $urandom_range(0, 1);
    wb_write_address = AW'($urandom_range(0, 7)); wb_write_data = $urandom();
    out_ready = ($urandom_range(0, 3) != 0);
    flush = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    int stalls, caps, valids;
    model_reset();
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_rd", out_rd, 0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clock); @(negedge clock);
    reset = 1;
    idle_inputs();

    // Bypass of same-cycle writeback, and register 0 forced to zero
    drive_instr(3, 1, 4, 1, 0);
    rf_data_1 = 32'h11; wb_write_enable = 1; wb_write_address = 3; wb_write_data = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    #1 check("bypass_a", out_operand_a, 32'hDEADBEEF);
    drive_instr(0, 1, 4, 1, 0);
    rf_data_1 = 32'h11; wb_write_enable = 1; wb_write_address = 0; wb_write_data = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    #1 check("zero_reg_a", out_operand_a, 0);
    cycle(); cycle();

    // Load-use: two bubbles with out_ready held high
    drive_instr(1, 2, 5, 1, 1);
    cycle();
    drive_instr(5, 6, 7, 1, 0);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_ready) break;
      stalls++;
    end
    idle_inputs();
    check("load_use_bubbles", stalls, 2);
    cycle(); cycle();

    // Hold for 4 cycles with a second instruction pending, then pass-through
    drive_instr(1, 2, 3, 1, 0);
    cycle();
    drive_instr(4, 6, 8, 1, 0);
    out_ready = 0;
    for (int i = 0; i < 4; i++) cycle();
    out_ready = 1;
    cycle();
    check("pass_through_ready", obs_ready, 1);
    idle_inputs();
    cycle(); cycle();

    // Flush kills held load and its shadow; dependent follows without stall
    drive_instr(1, 2, 9, 1, 1);
    cycle();
    drive_instr(9, 1, 10, 1, 0);
    flush = 1;
    cycle();
    flush = 0;
    cycle();
    check("after_flush_ready", obs_ready, 1);
    idle_inputs();
    cycle(); cycle();

    // Back-to-back independent instructions, no bubbles
    caps = 0; valids = 0;
    for (int i = 0; i < 8; i++) begin
      drive_instr(AW'($urandom_range(1, 7)), AW'($urandom_range(1, 7)),
                  AW'($urandom_range(1, 7)), 1, 0);
      cycle();
      if (obs_ready) caps++;
      if (i > 0 && obs_valid) valids++;
    end
    check("b2b_captures", caps, 8);
    check("b2b_valid_run", valids, 7);

    // Asynchronous reset while an entry is held
    drive_instr(1, 2, 7, 1, 0);
    rf_data_1 = 32'hA5A5_0001;
    cycle();
    idle_inputs();
    #2 reset = 0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_operand_a", out_operand_a, 0);
    check("async_out_rd", out_rd, 0);
    model_reset();
    @(negedge clock);
    reset = 1;
    drive_instr(2, 3, 4, 1, 0);
    cycle();
    idle_inputs();
    cycle();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive_random();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
